// File: rtl/goertzel_pkg.sv
// Shared types, constants and the fixed-point coefficient multiply for the Goertzel receiver.
package goertzel_pkg;

    typedef enum logic [2:0] {
        ACCEPT = 3'd0,
        ITER   = 3'd1,
        PA     = 3'd2,
        PB     = 3'd3,
        PC     = 3'd4,
        PD     = 3'd5,
        OUT    = 3'd6
    } state_t;

    localparam int unsigned SAMPLE_OFFSET = 128;
    localparam int unsigned SAMPLE_W      = 8;
    localparam int unsigned X_W           = 9;
    localparam int unsigned COEF_W        = 16;
    localparam int unsigned SW_MAX        = 64;
    localparam int unsigned PROD_W        = SW_MAX + COEF_W;

    // Full-width signed product, arithmetic shift; callers truncate to their state width.
    function automatic logic signed [SW_MAX-1:0] coef_mul(
        input logic signed [COEF_W-1:0] coef,
        input logic signed [SW_MAX-1:0] s,
        input int unsigned              frac
    );
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(coef) * PROD_W'(s);
        prod = prod >>> frac;
        return SW_MAX'(prod);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous control bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/goertzel_rx.sv
// Goertzel single-bin detector: consumes ADC samples, runs the recursion over N samples,
// then presents the bin power on a valid/ready result handshake.
module goertzel_rx
    import goertzel_pkg::*;
#(
    parameter int unsigned        N    = 205,
    parameter logic signed [15:0] COEF = 16'sd27980,
    parameter int unsigned        FRAC = 14,
    parameter int unsigned        SW   = 32,
    parameter int unsigned        PW   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [SAMPLE_W-1:0]  sample,
    output logic                 ready,
    output logic signed [PW-1:0] power,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 overrun
);

    localparam int unsigned CNT_W = $clog2(N + 1);

    state_t                state;
    logic                  valid_s;
    logic                  valid_d;
    logic                  valid_edge;
    logic                  pending;
    logic [CNT_W-1:0]      count;
    logic signed [X_W-1:0] x_c;
    logic signed [X_W-1:0] x_reg;
    logic signed [SW-1:0]  s1;
    logic signed [SW-1:0]  s2;
    logic signed [SW-1:0]  t_it;
    logic signed [SW-1:0]  s_new;
    logic signed [SW-1:0]  t_reg;
    logic signed [PW-1:0]  pa;
    logic signed [PW-1:0]  pb;
    logic                  last_iter;

    sync_2ff u_sync_valid (
        .clk (clk),
        .rst (rst),
        .d   (valid),
        .q   (valid_s)
    );

    // One edge per valid pulse, independent of how long the ADC holds valid.
    assign valid_edge = valid_s & ~valid_d;
    assign x_c        = $signed({1'b0, sample} - X_W'(SAMPLE_OFFSET));
    assign t_it       = SW'(coef_mul(COEF, SW_MAX'(s1), FRAC));
    assign s_new      = SW'(x_reg) + t_it - s2;
    assign last_iter  = (count == CNT_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCEPT;
            valid_d      <= 1'b0;
            ready        <= 1'b0;
            result_valid <= 1'b0;
            power        <= '0;
            overrun      <= 1'b0;
            pending      <= 1'b0;
            count        <= '0;
            x_reg        <= '0;
            s1           <= '0;
            s2           <= '0;
            t_reg        <= '0;
            pa           <= '0;
            pb           <= '0;
        end else begin
            valid_d <= valid_s;

            // Samples arriving while the block is being finished are dropped.
            if (valid_edge && (state inside {PA, PB, PC, PD, OUT}))
                overrun <= 1'b1;

            case (state)
                ACCEPT: begin
                    ready <= 1'b1;
                    if (valid_edge || pending) begin
                        x_reg   <= x_c;
                        pending <= 1'b0;
                        state   <= ITER;
                    end
                end
                ITER: begin
                    s2    <= s1;
                    s1    <= s_new;
                    count <= count + CNT_W'(1);
                    if (last_iter) begin
                        ready <= 1'b0;
                        state <= PA;
                        if (valid_edge)
                            overrun <= 1'b1;
                    end else begin
                        ready <= 1'b1;
                        state <= ACCEPT;
                        if (valid_edge)
                            pending <= 1'b1;
                    end
                end
                PA: begin
                    pa    <= PW'(s1) * PW'(s1);
                    state <= PB;
                end
                PB: begin
                    pb    <= PW'(s2) * PW'(s2);
                    state <= PC;
                end
                PC: begin
                    t_reg <= t_it;
                    state <= PD;
                end
                PD: begin
                    power        <= pa + pb - PW'(t_reg) * PW'(s2);
                    result_valid <= 1'b1;
                    state        <= OUT;
                end
                OUT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        s1           <= '0;
                        s2           <= '0;
                        count        <= '0;
                        ready        <= 1'b1;
                        state        <= ACCEPT;
                    end
                end
                default: state <= ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_goertzel_rx.sv
// Directed bench for goertzel_rx: two instances (COEF=0 and COEF=1.5) with N=4 share one stimulus.
module tb_goertzel_rx;

    logic               clk;
    logic               rst;
    logic               valid;
    logic [7:0]         sample;
    logic               result_ready;
    logic               ready0, rv0, ovr0;
    logic               ready1, rv1, ovr1;
    logic signed [63:0] power0, power1;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [3:0][7:0] smp;
        longint          p0;
        longint          p1;
    } vec_t;

    vec_t vecs [6];

    goertzel_rx #(.N(4), .COEF(16'sd0), .FRAC(14), .SW(32), .PW(64)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .valid        (valid),
        .sample       (sample),
        .ready        (ready0),
        .power        (power0),
        .result_valid (rv0),
        .result_ready (result_ready),
        .overrun      (ovr0)
    );

    goertzel_rx #(.N(4), .COEF(16'sd24576), .FRAC(14), .SW(32), .PW(64)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .valid        (valid),
        .sample       (sample),
        .ready        (ready1),
        .power        (power1),
        .result_valid (rv1),
        .result_ready (result_ready),
        .overrun      (ovr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // One ADC sample: valid high 20 clk, period 251 clk.
    task automatic pulse(input logic [7:0] s);
        sample = s;
        valid  = 1'b1;
        cyc(20);
        valid  = 1'b0;
        cyc(231);
    endtask

    task automatic send_block(input logic [3:0][7:0] smp);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("no_result_before_last", longint'(rv0), 0);
            pulse(smp[i]);
        end
    endtask

    task automatic take_result();
        result_ready = 1'b1;
        cyc(1);
        result_ready = 1'b0;
        check("rv0_after_take", longint'(rv0), 0);
        check("rv1_after_take", longint'(rv1), 0);
        check("ready0_after_take", longint'(ready0), 1);
        check("ready1_after_take", longint'(ready1), 1);
    endtask

    function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d,
                                input longint p0, input longint p1);
        vec_t v;
        v.smp = {d, c, b, a};
        v.p0  = p0;
        v.p1  = p1;
        return v;
    endfunction

    initial begin
        logic [3:0][7:0] tone;
        n_chk        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        valid        = 1'b0;
        sample       = 8'd0;
        result_ready = 1'b0;
        tone         = {8'd128, 8'd127, 8'd128, 8'd129};

        vecs[0] = mk(8'd128, 8'd128, 8'd128, 8'd128, 0,     0);
        vecs[1] = mk(8'd129, 8'd128, 8'd127, 8'd128, 4,     5);
        vecs[2] = mk(8'd0,   8'd128, 8'd128, 8'd128, 16384, 16384);
        vecs[3] = mk(8'd255, 8'd128, 8'd128, 8'd128, 16129, 16113);
        vecs[4] = mk(8'd128, 8'd128, 8'd255, 8'd0,   32513, 8162);
        vecs[5] = mk(8'd127, 8'd128, 8'd128, 8'd128, 1,     1);

        // Reset values
        cyc(5);
        check("rst_ready", longint'(ready0), 0);
        check("rst_rv", longint'(rv0), 0);
        check("rst_power", power0, 0);
        check("rst_overrun", longint'(ovr0), 0);
        rst = 1'b0;
        cyc(1);
        check("ready_after_rst", longint'(ready0), 1);

        // Table of blocks
        for (int k = 0; k < 6; k++) begin
            send_block(vecs[k].smp);
            check($sformatf("v%0d_rv", k), longint'(rv0), 1);
            check($sformatf("v%0d_power0", k), power0, vecs[k].p0);
            check($sformatf("v%0d_power1", k), power1, vecs[k].p1);
            check($sformatf("v%0d_ready_low", k), longint'(ready0), 0);
            check($sformatf("v%0d_overrun", k), longint'(ovr0), 0);
            take_result();
        end

        // Exact latency on the last sample of a block
        pulse(8'd129);
        pulse(8'd128);
        pulse(8'd127);
        check("lat_no_result", longint'(rv0), 0);
        sample = 8'd128;
        valid  = 1'b1;
        cyc(3);
        check("lat_ready_at_capture", longint'(ready0), 1);
        cyc(1);
        check("lat_ready_drop", longint'(ready0), 0);
        check("lat_rv_not_yet", longint'(rv0), 0);
        cyc(3);
        check("lat_rv_still_low", longint'(rv0), 0);
        cyc(1);
        check("lat_rv_rise", longint'(rv0), 1);
        check("lat_rv1_rise", longint'(rv1), 1);
        cyc(12);
        valid = 1'b0;
        cyc(231);
        check("lat_power0", power0, 4);
        check("lat_power1", power1, 5);

        // Backpressure: result held, one dropped sample during OUT
        cyc(300);
        check("bp_rv_held", longint'(rv0), 1);
        check("bp_power_held", power0, 4);
        pulse(8'd255);
        check("bp_rv_after_drop", longint'(rv0), 1);
        check("bp_power_after_drop", power0, 4);
        check("bp_ready_low", longint'(ready0), 0);
        check("bp_overrun0", longint'(ovr0), 1);
        check("bp_overrun1", longint'(ovr1), 1);
        take_result();
        send_block(tone);
        check("bp_next_rv", longint'(rv0), 1);
        check("bp_next_power0", power0, 4);
        check("bp_next_power1", power1, 5);
        check("bp_overrun_sticky", longint'(ovr0), 1);
        take_result();

        // Reset mid-block discards the partial block
        pulse(8'd255);
        pulse(8'd0);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check("mid_rst_overrun", longint'(ovr0), 0);
        check("mid_rst_ready", longint'(ready0), 1);
        send_block(tone);
        check("mid_rst_rv", longint'(rv0), 1);
        check("mid_rst_power0", power0, 4);
        check("mid_rst_power1", power1, 5);
        take_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
